mbist_host_ctrl: RTL and testbench

- Session initiator for the on-chip MBIST/MBISR engine. Drives the engine's `start`, waits for `done`, captures `fail`, and reports a latched verdict with a watchdog timeout.
- Takes an asynchronous pin-level request (a `ui_in` bit), so a bare tile can self-test from a single button.
- Sits between the TinyTapeout pin wrapper and the engine's start/done/fail interface.

---
 rtl/mbist_host_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mbist_host_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_host_ctrl.sv
// MBIST session initiator: synchronized go request, start pulse, done/fail capture, watchdog, latched verdict.
// Optional feature macro MBIST_HOST_RETRY_EN: one retry after a first-attempt fail, reporting repaired on a second-pass success.
module mbist_host_ctrl #(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 40000,
  parameter int unsigned START_LEN      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  output logic       bist_start,
  input  logic       bist_done,
  input  logic       bist_fail,
  output logic       busy,
  output logic       result_valid,
  output logic       pass,
  output logic       fail,
  output logic       timeout,
  output logic       repaired,
  output logic [3:0] run_cnt
);

  typedef enum logic [2:0] {IDLE, START, WAIT, SETTLE, REPORT} state_t;

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       go_sync;
  logic             go_rise;
  logic             seen_low, seen_low_nxt;
  logic             pend_fail, pend_fail_nxt;
  logic             pend_to, pend_to_nxt;
  logic             pass_r, pass_nxt;
  logic             fail_r, fail_nxt;
  logic             timeout_r, timeout_nxt;
  logic [3:0]       run_cnt_r, run_cnt_nxt;
`ifdef MBIST_HOST_RETRY_EN
  logic             retry, retry_nxt;
  logic             repaired_r, repaired_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_sync   <= '0;
      go_rise   <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      seen_low  <= 1'b0;
      pend_fail <= 1'b0;
      pend_to   <= 1'b0;
      pass_r    <= 1'b0;
      fail_r    <= 1'b0;
      timeout_r <= 1'b0;
      run_cnt_r <= '0;
    end else begin
      go_sync   <= {go_sync[1:0], go};
      go_rise   <= go_sync[1] & ~go_sync[2];
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      seen_low  <= seen_low_nxt;
      pend_fail <= pend_fail_nxt;
      pend_to   <= pend_to_nxt;
      pass_r    <= pass_nxt;
      fail_r    <= fail_nxt;
      timeout_r <= timeout_nxt;
      run_cnt_r <= run_cnt_nxt;
    end
  end

`ifdef MBIST_HOST_RETRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry      <= 1'b0;
      repaired_r <= 1'b0;
    end else begin
      retry      <= retry_nxt;
      repaired_r <= repaired_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    seen_low_nxt  = seen_low;
    pend_fail_nxt = pend_fail;
    pend_to_nxt   = pend_to;
    pass_nxt      = pass_r;
    fail_nxt      = fail_r;
    timeout_nxt   = timeout_r;
    run_cnt_nxt   = run_cnt_r;
`ifdef MBIST_HOST_RETRY_EN
    retry_nxt     = retry;
    repaired_nxt  = repaired_r;
`endif
    case (state)
      IDLE: begin
        if (go_rise) begin
          pass_nxt     = 1'b0;
          fail_nxt     = 1'b0;
          timeout_nxt  = 1'b0;
`ifdef MBIST_HOST_RETRY_EN
          retry_nxt    = 1'b0;
          repaired_nxt = 1'b0;
`endif
          cnt_nxt      = '0;
          seen_low_nxt = 1'b0;
          state_nxt    = START;
        end
      end
      START: begin
        if (!bist_done) seen_low_nxt = 1'b1;
        if (cnt == START_LAST) begin
          cnt_nxt   = '0;
          state_nxt = WAIT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT: begin
        cnt_nxt = cnt + 1'b1;
        if (!bist_done) seen_low_nxt = 1'b1;
        // A done only counts once it has been seen low since START; done beats the watchdog.
        if (bist_done && seen_low) begin
          pend_fail_nxt = bist_fail;
          pend_to_nxt   = 1'b0;
          state_nxt     = SETTLE;
        end else if (cnt == TO_LAST) begin
          pend_fail_nxt = 1'b0;
          pend_to_nxt   = 1'b1;
          state_nxt     = SETTLE;
        end
      end
      SETTLE: begin
`ifdef MBIST_HOST_RETRY_EN
        if (pend_fail && !retry) begin
          retry_nxt    = 1'b1;
          cnt_nxt      = '0;
          seen_low_nxt = 1'b0;
          state_nxt    = START;
        end else begin
          pass_nxt     = !pend_fail && !pend_to;
          fail_nxt     = pend_fail;
          timeout_nxt  = pend_to;
          repaired_nxt = retry && !pend_fail && !pend_to;
          state_nxt    = REPORT;
        end
`else
        pass_nxt    = !pend_fail && !pend_to;
        fail_nxt    = pend_fail;
        timeout_nxt = pend_to;
        state_nxt   = REPORT;
`endif
      end
      REPORT: begin
        if (run_cnt_r != 4'hF) run_cnt_nxt = run_cnt_r + 4'd1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bist_start   = (state == START);
  assign busy         = (state != IDLE);
  assign result_valid = (state == REPORT);
  assign pass         = pass_r;
  assign fail         = fail_r;
  assign timeout      = timeout_r;
  assign run_cnt      = run_cnt_r;
`ifdef MBIST_HOST_RETRY_EN
  assign repaired     = repaired_r;
`else
  assign repaired     = 1'b0;
`endif

endmodule

// File: tb/tb_mbist_host_ctrl.sv
// Self-checking bench for mbist_host_ctrl: randomized engine latencies/verdicts against a cycle-arithmetic session model.
module tb_mbist_host_ctrl;
  localparam int SL = 2;
  localparam int TO = 150;
  localparam int NEVER = 100000;

  logic       clk = 1'b0;
  logic       rst_n, go;
  logic       bist_done = 1'b0, bist_fail = 1'b0;
  logic       bist_start, busy, result_valid, pass, fail, timeout, repaired;
  logic [3:0] run_cnt;

  mbist_host_ctrl #(.CNT_W(16), .TIMEOUT_CYCLES(TO), .START_LEN(SL)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .bist_start(bist_start), .bist_done(bist_done),
    .bist_fail(bist_fail), .busy(busy), .result_valid(result_valid), .pass(pass),
    .fail(fail), .timeout(timeout), .repaired(repaired), .run_cnt(run_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0, n_pass = 0, exp_run = 0;

  // Monitor: start pulses, their lengths, result_valid high cycles.
  int   mon_starts = 0, mon_rv_hi = 0, last_rv_cyc = -1, last_start_len = 0, cur_len = 0;
  int   start_cyc_q[$];
  logic mon_prev = 1'b0;
  always @(negedge clk) begin
    if (bist_start) begin
      if (!mon_prev) begin mon_starts++; start_cyc_q.push_back(cyc); cur_len = 0; end
      cur_len++;
    end else if (mon_prev) last_start_len = cur_len;
    if (result_valid) begin mon_rv_hi++; last_rv_cyc = cyc; end
    mon_prev = bist_start;
  end

  // Engine model: drops done on start, raises done after cfg_lat WAIT cycles.
  int cfg_lat[2];
  bit cfg_fail[2];
  bit cfg_stale = 1'b0;
  int cfg_sess = 0;
  int e_sess = -1, e_att = 0, e_cur = 0, e_idx = 0;
  bit e_wait = 1'b0, e_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      e_wait = 1'b0; e_prev = 1'b0;
    end else begin
      if (e_sess != cfg_sess) begin e_sess = cfg_sess; e_att = 0; end
      if (bist_start && !e_prev) begin
        e_cur = (e_att > 1) ? 1 : e_att;
        e_att++;
        e_wait = 1'b0;
        if (cfg_stale && e_cur == 0) begin bist_done = 1'b1; bist_fail = 1'b1; end
        else bist_done = 1'b0;
      end
      if (!bist_start && e_prev) begin e_wait = 1'b1; e_idx = 0; end
      else if (e_wait) e_idx++;
      if (e_wait) begin
        if (cfg_stale && e_cur == 0 && e_idx == 3) bist_done = 1'b0;
        if (e_idx == cfg_lat[e_cur]) begin
          bist_done = 1'b1; bist_fail = cfg_fail[e_cur]; e_wait = 1'b0;
        end
      end
      e_prev = bist_start;
    end
  end

  task automatic run_session(input int lat1, input bit f1, input int lat2, input bit f2,
                             input bit stale, input bit tog);
    int c, s0, rv0, att, e_rv, e_s2, w1, w2;
    bit ep, ef, et, er, retry_on, done_seen;
`ifdef MBIST_HOST_RETRY_EN
    retry_on = 1'b1;
`else
    retry_on = 1'b0;
`endif
    {ep, ef, et, er} = '0;
    e_s2 = 0;
    w1 = SL + 4;
    if (lat1 >= TO) begin
      att = 1; et = 1'b1; e_rv = w1 + TO + 1;
    end else if (f1 && retry_on) begin
      att = 2; e_s2 = w1 + lat1 + 2; w2 = e_s2 + SL;
      if (lat2 >= TO) begin et = 1'b1; e_rv = w2 + TO + 1; end
      else begin e_rv = w2 + lat2 + 2; ef = f2; ep = !f2; er = !f2; end
    end else begin
      att = 1; ep = !f1; ef = f1; e_rv = w1 + lat1 + 2;
    end
    exp_run = (exp_run < 15) ? exp_run + 1 : 15;

    cfg_lat[0] = lat1; cfg_lat[1] = lat2; cfg_fail[0] = f1; cfg_fail[1] = f2;
    cfg_stale = stale; cfg_sess++;
    @(negedge clk); #1;
    s0 = mon_starts; rv0 = mon_rv_hi;
    go = 1'b1; c = cyc;
    done_seen = 1'b0;
    for (int r = 1; r <= 2 * TO + 300 && !done_seen; r++) begin
      @(negedge clk); #1;
      if (r == 6) go = 1'b0;
      if (tog && (r == SL + 12 || r == SL + 24)) go = 1'b1;
      if (tog && (r == SL + 16 || r == SL + 28)) go = 1'b0;
      if (r == 3) begin
        n_checks++;
        if (bist_start !== 1'b0 || busy !== 1'b0) $display("FAIL early_start: start=%b busy=%b expected 0 0", bist_start, busy);
        else n_pass++;
      end
      if (r == 4) begin
        n_checks++;
        if (bist_start !== 1'b1 || busy !== 1'b1) $display("FAIL start_k3: start=%b busy=%b expected 1 1", bist_start, busy);
        else n_pass++;
        n_checks++;
        if ({pass, fail, timeout, repaired} !== 4'b0) $display("FAIL verdict_clear: got %b expected 0000", {pass, fail, timeout, repaired});
        else n_pass++;
      end
      if (r > 4 && !busy && mon_rv_hi > rv0) done_seen = 1'b1;
    end
    n_checks++;
    if (!done_seen) $display("FAIL session_end: busy=%b rv_seen=%0d expected session to finish", busy, mon_rv_hi - rv0);
    else n_pass++;
    repeat (8) @(negedge clk);
    #1;
    n_checks++;
    if (mon_starts - s0 !== att) $display("FAIL start_count: got %0d expected %0d", mon_starts - s0, att);
    else n_pass++;
    n_checks++;
    if (start_cyc_q.size() <= s0 || start_cyc_q[s0] !== c + 4) $display("FAIL start_cycle: got q size %0d expected rise at %0d", start_cyc_q.size(), c + 4);
    else n_pass++;
    if (att == 2) begin
      n_checks++;
      if (start_cyc_q.size() <= s0 + 1 || start_cyc_q[s0 + 1] !== c + e_s2) $display("FAIL retry_start_cycle: expected rise at %0d", c + e_s2);
      else n_pass++;
    end
    n_checks++;
    if (last_start_len !== SL) $display("FAIL start_len: got %0d expected %0d", last_start_len, SL);
    else n_pass++;
    n_checks++;
    if (mon_rv_hi - rv0 !== 1) $display("FAIL rv_pulses: got %0d expected 1", mon_rv_hi - rv0);
    else n_pass++;
    n_checks++;
    if (last_rv_cyc !== c + e_rv) $display("FAIL rv_cycle: got %0d expected %0d", last_rv_cyc - c, e_rv);
    else n_pass++;
    n_checks++;
    if ({pass, fail, timeout, repaired} !== {ep, ef, et, er})
      $display("FAIL verdict: got p/f/t/r=%b expected %b", {pass, fail, timeout, repaired}, {ep, ef, et, er});
    else n_pass++;
    n_checks++;
    if (run_cnt !== 4'(exp_run)) $display("FAIL run_cnt: got %0d expected %0d", run_cnt, exp_run);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; go = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({bist_start, busy, result_valid, pass, fail, timeout, repaired, run_cnt} !== 11'b0)
      $display("FAIL reset_state: got %b expected all 0", {bist_start, busy, result_valid, pass, fail, timeout, repaired, run_cnt});
    else n_pass++;
    rst_n = 1'b1;
    exp_run = 0;
  endtask

  task automatic test_pass_basic();
    run_session(100, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_fail();
    run_session($urandom_range(5, 60), 1'b1, $urandom_range(5, 60), 1'b0, 1'b0, 1'b0);
    run_session($urandom_range(5, 60), 1'b1, $urandom_range(5, 60), 1'b1, 1'b0, 1'b0);
    run_session($urandom_range(5, 60), 1'b1, NEVER, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    run_session(NEVER, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_session(TO, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_done_wins();
    run_session(TO - 1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_session(TO - 2, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stale_done();
    run_session(20, 1'b0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_go_toggle();
    run_session(60, 1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_session($urandom_range(1, TO + 5), 1'($urandom_range(0, 1)),
                  $urandom_range(1, TO + 5), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 17; i++)
      run_session($urandom_range(2, 40), 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort();
    cfg_lat[0] = NEVER; cfg_lat[1] = NEVER; cfg_stale = 1'b0; cfg_sess++;
    @(negedge clk); #1;
    go = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    go = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || run_cnt !== 4'(exp_run)) $display("FAIL abort_pre: busy=%b run_cnt=%0d expected 1 %0d", busy, run_cnt, exp_run);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bist_start, busy, result_valid, pass, fail, timeout, repaired, run_cnt} !== 11'b0)
      $display("FAIL abort_state: got %b expected all 0", {bist_start, busy, result_valid, pass, fail, timeout, repaired, run_cnt});
    else n_pass++;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    exp_run = 0;
    run_session(30, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_pass_basic();
    test_fail();
    test_timeout();
    test_done_wins();
    test_stale_done();
    test_go_toggle();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
